// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared arithmetic types and constants for the divider
package arith_pkg;

    localparam int DIV_N     = 16;
    localparam int DIV_M     = 8;
    localparam int DIV_CNT_W = $clog2(DIV_N);

    // Quotient reported when the divisor is zero
    localparam logic [DIV_N-1:0] DIV_BY_ZERO_Q = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring division iteration
module div_step #(
    parameter int M = 8
) (
    input  logic [M:0]   r_in,
    input  logic         q_msb,
    input  logic [M-1:0] d,
    output logic [M:0]   r_out,
    output logic         q_bit
);

    logic [M:0]   r_shift;
    logic [M+1:0] trial;

    // Shift in the next dividend bit, subtract the divisor, keep the result if non-negative
    always_comb begin
        r_shift = {r_in[M-1:0], q_msb};
        trial   = {1'b0, r_shift} - {2'b00, d};
        q_bit   = ~trial[M+1];
        r_out   = trial[M+1] ? r_shift : trial[M:0];
    end

endmodule

// File: rtl/restoring_divider_16_8.sv
// rtl/restoring_divider_16_8.sv - iterative radix-2 restoring divider with valid/ready handshakes
module restoring_divider_16_8
    import arith_pkg::*;
#(
    parameter int N = DIV_N,
    parameter int M = DIV_M
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] dividend,
    input  logic [M-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] quotient,
    output logic [M-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = $clog2(N);

    div_state_e   state_q, state_d;
    logic [N-1:0] q_q, q_d;
    logic [M:0]   r_q, r_d;
    logic [M-1:0] d_q, d_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic         dz_q, dz_d;
    logic         out_valid_q, out_valid_d;
    logic [N-1:0] quotient_q, quotient_d;
    logic [M-1:0] remainder_q, remainder_d;
    logic         div_by_zero_q, div_by_zero_d;

    logic [M:0]   step_r;
    logic         step_qbit;

    div_step #(.M(M)) u_step (
        .r_in  (r_q),
        .q_msb (q_q[N-1]),
        .d     (d_q),
        .r_out (step_r),
        .q_bit (step_qbit)
    );

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = out_valid_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;

    // Next-state: capture operands, iterate, then publish the result once and wait for the consumer
    always_comb begin
        state_d       = state_q;
        q_d           = q_q;
        r_d           = r_q;
        d_d           = d_q;
        cnt_d         = cnt_q;
        dz_d          = dz_q;
        out_valid_d   = out_valid_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    q_d     = dividend;
                    r_d     = '0;
                    d_d     = divisor;
                    cnt_d   = '0;
                    dz_d    = (divisor == '0);
                    state_d = (divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                q_d   = {q_q[N-2:0], step_qbit};
                r_d   = step_r;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // First DONE cycle loads the output registers; Q still holds the dividend on divide by zero
                if (!out_valid_q) begin
                    out_valid_d   = 1'b1;
                    quotient_d    = dz_q ? N'(DIV_BY_ZERO_Q) : q_q;
                    remainder_d   = dz_q ? q_q[M-1:0] : r_q[M-1:0];
                    div_by_zero_d = dz_q;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset taking priority over everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            q_q           <= '0;
            r_q           <= '0;
            d_q           <= '0;
            cnt_q         <= '0;
            dz_q          <= 1'b0;
            out_valid_q   <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            q_q           <= q_d;
            r_q           <= r_d;
            d_q           <= d_d;
            cnt_q         <= cnt_d;
            dz_q          <= dz_d;
            out_valid_q   <= out_valid_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

endmodule

// File: tb/tb_restoring_divider_16_8.sv
// tb/tb_restoring_divider_16_8.sv - randomized self-checking bench for restoring_divider_16_8
module tb_restoring_divider_16_8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;

    // expectation for the operation currently in flight
    logic        exp_live = 1'b0;
    logic [15:0] exp_q;
    logic [7:0]  exp_r;
    logic        exp_dz;

    restoring_divider_16_8 dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // reference: plain integer division, divide by zero yields all ones and the low dividend byte
    function automatic logic [24:0] model(input logic [15:0] a, input logic [7:0] b);
        if (b == 8'd0) return {16'hFFFF, a[7:0], 1'b1};
        return {16'(a / b), 8'(a % b), 1'b0};
    endfunction

    // every cycle a result is presented it must match the reference and block new input
    always @(negedge clk) begin
        if (!rst && out_valid && exp_live) begin
            chk("quotient", {16'd0, quotient}, {16'd0, exp_q});
            chk("remainder", {24'd0, remainder}, {24'd0, exp_r});
            chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, exp_dz});
            chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
        end
    end

    // present one operation, check latency, optionally hold off the consumer; returns final result
    task automatic run_op(input logic [15:0] a, input logic [7:0] b, input int hold,
                          output logic [15:0] got_q, output logic [7:0] got_r);
        logic [24:0] m;
        int k;
        int guard;
        int exp_k;
        m = model(a, b);
        @(negedge clk);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) chk("in_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        exp_q = m[24:9];
        exp_r = m[8:1];
        exp_dz = m[0];
        exp_live = 1'b1;
        exp_k = (b == 8'd0) ? 2 : 18;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            // operands are don't-care while busy
            in_valid = 1'($urandom_range(0, 1));
            dividend = 16'($urandom);
            divisor  = 8'($urandom);
        end while (!out_valid && k < 40);
        chk("latency", k, exp_k);
        in_valid = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
        end
        got_q = quotient;
        got_r = remainder;
        out_ready = 1'b1;
        @(negedge clk);
        exp_live = 1'b0;
        out_ready = 1'b0;
        chk("out_valid_drop", {31'd0, out_valid}, 32'd0);
        chk("in_ready_back", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [15:0] gq;
        logic [7:0]  gr;
        logic [24:0] pin;
        logic [15:0] a16;
        logic [7:0]  b8;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_quotient", {16'd0, quotient}, 32'd0);
        chk("rst_remainder", {24'd0, remainder}, 32'd0);
        chk("rst_dz", {31'd0, div_by_zero}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // hand-computed values pinning the reference model
        pin = model(16'hFFFF, 8'hFF);
        chk("model_ffff_ff", {7'd0, pin}, {7'd0, 16'h0101, 8'h00, 1'b0});
        pin = model(16'd1000, 8'd7);
        chk("model_1000_7", {7'd0, pin}, {7'd0, 16'd142, 8'd6, 1'b0});
        pin = model(16'h1234, 8'h00);
        chk("model_div0", {7'd0, pin}, {7'd0, 16'hFFFF, 8'h34, 1'b1});

        // directed operations with literal results
        run_op(16'hFFFF, 8'hFF, 0, gq, gr);
        chk("ffff_ff_q", {16'd0, gq}, 32'h0101);
        chk("ffff_ff_r", {24'd0, gr}, 32'h00);
        run_op(16'd1000, 8'd7, 1, gq, gr);
        chk("1000_7_q", {16'd0, gq}, 32'd142);
        chk("1000_7_r", {24'd0, gr}, 32'd6);
        run_op(16'h0005, 8'h09, 0, gq, gr);
        chk("5_9_q", {16'd0, gq}, 32'd0);
        chk("5_9_r", {24'd0, gr}, 32'd5);
        run_op(16'h1234, 8'h00, 0, gq, gr);
        chk("div0_q", {16'd0, gq}, 32'hFFFF);
        chk("div0_r", {24'd0, gr}, 32'h34);
        run_op(16'd60000, 8'd200, 5, gq, gr);
        chk("bp_q", {16'd0, gq}, 32'd300);

        // reset in the middle of CALC aborts the operation
        @(negedge clk);
        in_valid = 1'b1;
        dividend = 16'd4321;
        divisor = 8'd13;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        run_op(16'd200, 8'd10, 0, gq, gr);
        chk("200_10_q", {16'd0, gq}, 32'd20);
        chk("200_10_r", {24'd0, gr}, 32'd0);

        // round trip of multiplier products
        for (int t = 0; t < 1000; t++) begin
            a16 = 16'($urandom_range(0, 255));
            b8  = 8'($urandom_range(1, 255));
            run_op(a16 * {8'd0, b8}, b8, int'($urandom_range(0, 2)), gq, gr);
            chk("rt_q", {16'd0, gq}, {16'd0, a16});
            chk("rt_r", {24'd0, gr}, 32'd0);
        end

        // random dividends and divisors including zero
        for (int t = 0; t < 200; t++) begin
            a16 = 16'($urandom);
            b8  = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
            run_op(a16, b8, int'($urandom_range(0, 3)), gq, gr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
